// File: rtl/mrecn_param_store_decay_if.sv
// CSR-side configuration bus of the scheduler parameter store: write strobe plus a
// one-cycle-latency registered read port.
interface mrecn_param_store_decay_if #(
  parameter int unsigned SEL_WIDTH        = 4,
  parameter int unsigned PARAM_SEL_WIDTH  = 3,
  parameter int unsigned PARAM_DATA_WIDTH = 16
);
  logic                        cfg_wr_en;
  logic [SEL_WIDTH-1:0]        cfg_wr_fifo;
  logic [PARAM_SEL_WIDTH-1:0]  cfg_wr_param;
  logic [PARAM_DATA_WIDTH-1:0] cfg_wr_data;
  logic                        cfg_rd_en;
  logic [SEL_WIDTH-1:0]        cfg_rd_fifo;
  logic [PARAM_SEL_WIDTH-1:0]  cfg_rd_param;
  logic                        cfg_rd_valid;
  logic [PARAM_DATA_WIDTH-1:0] cfg_rd_data;

  modport master (
    output cfg_wr_en, cfg_wr_fifo, cfg_wr_param, cfg_wr_data,
    output cfg_rd_en, cfg_rd_fifo, cfg_rd_param,
    input  cfg_rd_valid, cfg_rd_data
  );

  modport slave (
    input  cfg_wr_en, cfg_wr_fifo, cfg_wr_param, cfg_wr_data,
    input  cfg_rd_en, cfg_rd_fifo, cfg_rd_param,
    output cfg_rd_valid, cfg_rd_data
  );
endinterface

// File: rtl/mrecn_param_store_decay.sv
// Per-FIFO scheduler parameter store with MRECN congestion tracking; severity decays one
// step per DECAY_PERIOD cycles and the shaped rate is derated while a FIFO is congested.
module mrecn_param_store_decay #(
  parameter int unsigned PORT_COUNT_RX        = 3,
  parameter int unsigned N_FIFO_PER_PORT      = 4,
  parameter int unsigned FIFO_SEL_WIDTH       = $clog2(N_FIFO_PER_PORT),
  parameter int unsigned NUM_FIFO             = PORT_COUNT_RX * N_FIFO_PER_PORT,
  parameter int unsigned SEL_WIDTH            = $clog2(NUM_FIFO),
  parameter int unsigned PKT_LEN_WIDTH        = 16,
  parameter int unsigned PARAM_SEL_WIDTH      = 3,
  parameter int unsigned PARAM_DATA_WIDTH     = 16,
  parameter int unsigned MRECN_RES_ID_WIDTH   = 2,
  parameter int unsigned MRECN_CONG_SEV_WIDTH = 3,
  parameter int unsigned DECAY_PERIOD         = 1024
) (
  input  logic                                          clk,
  input  logic                                          rst,
  mrecn_param_store_decay_if.slave                      cfg,
  input  logic [PORT_COUNT_RX-1:0]                      mrecn_mrce,
  input  logic [PORT_COUNT_RX*MRECN_RES_ID_WIDTH-1:0]   mrecn_res_id,
  input  logic [PORT_COUNT_RX*MRECN_CONG_SEV_WIDTH-1:0] mrecn_cong_sev,
  input  logic [PORT_COUNT_RX*FIFO_SEL_WIDTH-1:0]       mrecn_fifo_select,
  output logic [NUM_FIFO*SEL_WIDTH-1:0]                 ps_fifo_priority_out,
  output logic [NUM_FIFO-1:0]                           ps_fifo_enable_shaping_out,
  output logic [NUM_FIFO*PKT_LEN_WIDTH-1:0]             ps_fifo_max_rate_out,
  output logic [NUM_FIFO*PKT_LEN_WIDTH-1:0]             ps_fifo_drr_quantum_out,
  output logic [NUM_FIFO*PKT_LEN_WIDTH-1:0]             ps_fifo_starvation_timeout_out
);

  localparam int unsigned CntWidth = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  typedef logic [CntWidth-1:0] cnt_t;
  localparam cnt_t CntMax = cnt_t'(DECAY_PERIOD - 1);

  localparam logic [PARAM_SEL_WIDTH-1:0] ParPrio   = PARAM_SEL_WIDTH'(0);
  localparam logic [PARAM_SEL_WIDTH-1:0] ParShape  = PARAM_SEL_WIDTH'(1);
  localparam logic [PARAM_SEL_WIDTH-1:0] ParRate   = PARAM_SEL_WIDTH'(2);
  localparam logic [PARAM_SEL_WIDTH-1:0] ParQuant  = PARAM_SEL_WIDTH'(3);
  localparam logic [PARAM_SEL_WIDTH-1:0] ParStarv  = PARAM_SEL_WIDTH'(4);
  localparam logic [PARAM_SEL_WIDTH-1:0] ParStatus = PARAM_SEL_WIDTH'(5);

  typedef logic [PKT_LEN_WIDTH-1:0]        len_t;
  typedef logic [MRECN_RES_ID_WIDTH-1:0]   res_t;
  typedef logic [MRECN_CONG_SEV_WIDTH-1:0] sev_t;

  logic [SEL_WIDTH-1:0] prio_q [NUM_FIFO];
  logic [SEL_WIDTH-1:0] prio_d [NUM_FIFO];
  logic                 shape_q [NUM_FIFO];
  logic                 shape_d [NUM_FIFO];
  len_t                 rate_q [NUM_FIFO];
  len_t                 rate_d [NUM_FIFO];
  len_t                 quant_q [NUM_FIFO];
  len_t                 quant_d [NUM_FIFO];
  len_t                 starv_q [NUM_FIFO];
  len_t                 starv_d [NUM_FIFO];
  logic                 mrce_q [NUM_FIFO];
  logic                 mrce_d [NUM_FIFO];
  res_t                 res_q [NUM_FIFO];
  res_t                 res_d [NUM_FIFO];
  sev_t                 sev_q [NUM_FIFO];
  sev_t                 sev_d [NUM_FIFO];

  cnt_t                        cnt_q, cnt_d;
  logic                        tick;
  logic                        wr_valid;
  logic                        rd_valid_q;
  logic [PARAM_DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  logic [NUM_FIFO-1:0] evt_hit;
  res_t                evt_res [NUM_FIFO];
  sev_t                evt_sev [NUM_FIFO];

  assign wr_valid = cfg.cfg_wr_en && (32'(cfg.cfg_wr_fifo) < NUM_FIFO) &&
                    (cfg.cfg_wr_param <= ParStarv);
  assign tick     = (cnt_q == CntMax);

  for (genvar g = 0; g < NUM_FIFO; g++) begin : g_fifo
    localparam int unsigned Port = g / N_FIFO_PER_PORT;
    len_t shifted;

    // Port and local index are fixed per FIFO, so port targets can never overlap.
    assign evt_hit[g] = mrecn_mrce[Port] &&
        (mrecn_fifo_select[Port*FIFO_SEL_WIDTH +: FIFO_SEL_WIDTH] ==
         FIFO_SEL_WIDTH'(g % N_FIFO_PER_PORT));
    assign evt_res[g] = mrecn_res_id[Port*MRECN_RES_ID_WIDTH +: MRECN_RES_ID_WIDTH];
    assign evt_sev[g] = mrecn_cong_sev[Port*MRECN_CONG_SEV_WIDTH +: MRECN_CONG_SEV_WIDTH];

    // Congested rate floors at 1 unless software programmed 0 (FIFO disabled).
    assign shifted = rate_q[g] >> sev_q[g];
    assign ps_fifo_max_rate_out[g*PKT_LEN_WIDTH +: PKT_LEN_WIDTH] =
        (!mrce_q[g] || (rate_q[g] == '0)) ? rate_q[g] :
        (shifted == '0) ? len_t'(1) : shifted;

    assign ps_fifo_priority_out[g*SEL_WIDTH +: SEL_WIDTH]                  = prio_q[g];
    assign ps_fifo_enable_shaping_out[g]                                   = shape_q[g] | mrce_q[g];
    assign ps_fifo_drr_quantum_out[g*PKT_LEN_WIDTH +: PKT_LEN_WIDTH]        = quant_q[g];
    assign ps_fifo_starvation_timeout_out[g*PKT_LEN_WIDTH +: PKT_LEN_WIDTH] = starv_q[g];
  end

  always_comb begin
    cnt_d   = tick ? '0 : cnt_q + cnt_t'(1);
    prio_d  = prio_q;
    shape_d = shape_q;
    rate_d  = rate_q;
    quant_d = quant_q;
    starv_d = starv_q;
    mrce_d  = mrce_q;
    res_d   = res_q;
    sev_d   = sev_q;
    // Later assignments win: write > event > decay tick.
    for (int f = 0; f < NUM_FIFO; f++) begin
      if (tick && mrce_q[f]) begin
        if (sev_q[f] != '0) begin
          sev_d[f] = sev_q[f] - sev_t'(1);
        end else begin
          mrce_d[f] = 1'b0;
          res_d[f]  = '0;
        end
      end
      if (evt_hit[f]) begin
        mrce_d[f] = 1'b1;
        res_d[f]  = evt_res[f];
        sev_d[f]  = (evt_sev[f] > sev_q[f]) ? evt_sev[f] : sev_q[f];
      end
      if (wr_valid && (cfg.cfg_wr_fifo == SEL_WIDTH'(f))) begin
        mrce_d[f] = 1'b0;
        res_d[f]  = '0;
        sev_d[f]  = '0;
        case (cfg.cfg_wr_param)
          ParPrio:  prio_d[f]  = cfg.cfg_wr_data[SEL_WIDTH-1:0];
          ParShape: shape_d[f] = cfg.cfg_wr_data[0];
          ParRate:  rate_d[f]  = cfg.cfg_wr_data[PKT_LEN_WIDTH-1:0];
          ParQuant: quant_d[f] = cfg.cfg_wr_data[PKT_LEN_WIDTH-1:0];
          ParStarv: starv_d[f] = cfg.cfg_wr_data[PKT_LEN_WIDTH-1:0];
          default:  ;
        endcase
      end
    end
  end

  // Read data comes from pre-edge state, so a same-cycle write is not visible.
  always_comb begin
    rd_data_d = '0;
    if (32'(cfg.cfg_rd_fifo) < NUM_FIFO) begin
      case (cfg.cfg_rd_param)
        ParPrio:   rd_data_d = PARAM_DATA_WIDTH'(prio_q[cfg.cfg_rd_fifo]);
        ParShape:  rd_data_d = PARAM_DATA_WIDTH'(shape_q[cfg.cfg_rd_fifo]);
        ParRate:   rd_data_d = PARAM_DATA_WIDTH'(rate_q[cfg.cfg_rd_fifo]);
        ParQuant:  rd_data_d = PARAM_DATA_WIDTH'(quant_q[cfg.cfg_rd_fifo]);
        ParStarv:  rd_data_d = PARAM_DATA_WIDTH'(starv_q[cfg.cfg_rd_fifo]);
        ParStatus: rd_data_d = PARAM_DATA_WIDTH'({sev_q[cfg.cfg_rd_fifo],
                                                  res_q[cfg.cfg_rd_fifo],
                                                  mrce_q[cfg.cfg_rd_fifo]});
        default:   rd_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      for (int f = 0; f < NUM_FIFO; f++) begin
        prio_q[f]  <= SEL_WIDTH'(1);
        shape_q[f] <= 1'b0;
        rate_q[f]  <= len_t'(1);
        quant_q[f] <= len_t'(500);
        starv_q[f] <= len_t'(1000);
        mrce_q[f]  <= 1'b0;
        res_q[f]   <= '0;
        sev_q[f]   <= '0;
      end
    end else begin
      cnt_q      <= cnt_d;
      rd_valid_q <= cfg.cfg_rd_en;
      if (cfg.cfg_rd_en) begin
        rd_data_q <= rd_data_d;
      end
      prio_q  <= prio_d;
      shape_q <= shape_d;
      rate_q  <= rate_d;
      quant_q <= quant_d;
      starv_q <= starv_d;
      mrce_q  <= mrce_d;
      res_q   <= res_d;
      sev_q   <= sev_d;
    end
  end

  assign cfg.cfg_rd_valid = rd_valid_q;
  assign cfg.cfg_rd_data  = rd_data_q;

endmodule

// File: tb/tb_mrecn_param_store_decay.sv
// Directed bench for mrecn_param_store_decay: reset defaults, writes/reads, MRECN escalation,
// decay stepping, derating boundaries, invalid writes and mid-run reset.
module tb_mrecn_param_store_decay;

  localparam int unsigned P = 16;

  logic        clk;
  logic        rst;
  logic [2:0]  mrecn_mrce;
  logic [5:0]  mrecn_res_id;
  logic [8:0]  mrecn_cong_sev;
  logic [5:0]  mrecn_fifo_select;
  logic [47:0]  ps_fifo_priority_out;
  logic [11:0]  ps_fifo_enable_shaping_out;
  logic [191:0] ps_fifo_max_rate_out;
  logic [191:0] ps_fifo_drr_quantum_out;
  logic [191:0] ps_fifo_starvation_timeout_out;

  int n_checks = 0;
  int n_fail   = 0;
  int tb_cnt   = 0;

  mrecn_param_store_decay_if #(
    .SEL_WIDTH       (4),
    .PARAM_SEL_WIDTH (3),
    .PARAM_DATA_WIDTH(16)
  ) cfg_bus ();

  mrecn_param_store_decay #(
    .DECAY_PERIOD(P)
  ) dut (
    .clk                           (clk),
    .rst                           (rst),
    .cfg                           (cfg_bus),
    .mrecn_mrce                    (mrecn_mrce),
    .mrecn_res_id                  (mrecn_res_id),
    .mrecn_cong_sev                (mrecn_cong_sev),
    .mrecn_fifo_select             (mrecn_fifo_select),
    .ps_fifo_priority_out          (ps_fifo_priority_out),
    .ps_fifo_enable_shaping_out    (ps_fifo_enable_shaping_out),
    .ps_fifo_max_rate_out          (ps_fifo_max_rate_out),
    .ps_fifo_drr_quantum_out       (ps_fifo_drr_quantum_out),
    .ps_fifo_starvation_timeout_out(ps_fifo_starvation_timeout_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference phase of the free-running decay counter.
  always @(posedge clk) begin
    if (rst) tb_cnt <= 0;
    else     tb_cnt <= (tb_cnt == P - 1) ? 0 : tb_cnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] rate_of(input int f);
    return ps_fifo_max_rate_out[f*16 +: 16];
  endfunction
  function automatic logic [15:0] quant_of(input int f);
    return ps_fifo_drr_quantum_out[f*16 +: 16];
  endfunction
  function automatic logic [15:0] starv_of(input int f);
    return ps_fifo_starvation_timeout_out[f*16 +: 16];
  endfunction
  function automatic logic [3:0] prio_of(input int f);
    return ps_fifo_priority_out[f*4 +: 4];
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_wr(input int f, input int p, input int d);
    cfg_bus.cfg_wr_en    = 1'b1;
    cfg_bus.cfg_wr_fifo  = 4'(f);
    cfg_bus.cfg_wr_param = 3'(p);
    cfg_bus.cfg_wr_data  = 16'(d);
  endtask

  task automatic set_evt(input int port, input int sel, input int res, input int sev);
    mrecn_mrce[port]                = 1'b1;
    mrecn_fifo_select[port*2 +: 2]  = 2'(sel);
    mrecn_res_id[port*2 +: 2]       = 2'(res);
    mrecn_cong_sev[port*3 +: 3]     = 3'(sev);
  endtask

  task automatic idle_inputs();
    cfg_bus.cfg_wr_en = 1'b0;
    mrecn_mrce        = '0;
    mrecn_fifo_select = '0;
    mrecn_res_id      = '0;
    mrecn_cong_sev    = '0;
  endtask

  task automatic do_write(input int f, input int p, input int d);
    set_wr(f, p, d);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic pulse_evt(input int port, input int sel, input int res, input int sev);
    set_evt(port, sel, res, sev);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic do_read(input int f, input int p, output logic v, output logic [15:0] d);
    cfg_bus.cfg_rd_en    = 1'b1;
    cfg_bus.cfg_rd_fifo  = 4'(f);
    cfg_bus.cfg_rd_param = 3'(p);
    @(negedge clk);
    cfg_bus.cfg_rd_en = 1'b0;
    v = cfg_bus.cfg_rd_valid;
    d = cfg_bus.cfg_rd_data;
  endtask

  // Returns at the negedge just after the next decay-tick edge.
  task automatic wait_tick();
    for (int i = 0; i <= int'(P); i++) begin
      if (tb_cnt == int'(P) - 1) break;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  logic        rv;
  logic [15:0] rd;
  int          exp1 [6] = '{1, 0, 1, 500, 1000, 0};

  initial begin
    rst = 1'b1;
    idle_inputs();
    cfg_bus.cfg_wr_fifo  = '0;
    cfg_bus.cfg_wr_param = '0;
    cfg_bus.cfg_wr_data  = '0;
    cfg_bus.cfg_rd_en    = 1'b0;
    cfg_bus.cfg_rd_fifo  = '0;
    cfg_bus.cfg_rd_param = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 1: reset state and readback of FIFO 5
    check_eq("rst_rd_valid", 32'(cfg_bus.cfg_rd_valid), 0);
    check_eq("rst_rd_data", 32'(cfg_bus.cfg_rd_data), 0);
    check_eq("rst_rate5", 32'(rate_of(5)), 1);
    check_eq("rst_shape5", 32'(ps_fifo_enable_shaping_out[5]), 0);
    check_eq("rst_prio5", 32'(prio_of(5)), 1);
    check_eq("rst_quant5", 32'(quant_of(5)), 500);
    check_eq("rst_starv5", 32'(starv_of(5)), 1000);
    for (int p = 0; p < 6; p++) begin
      do_read(5, p, rv, rd);
      check_eq($sformatf("rd5_valid_p%0d", p), 32'(rv), 1);
      check_eq($sformatf("rd5_data_p%0d", p), 32'(rd), 32'(exp1[p]));
    end
    @(negedge clk);
    check_eq("rd_valid_drop", 32'(cfg_bus.cfg_rd_valid), 0);

    // 2: program rate, then congest FIFO 6 via port 1 sel 2
    wait_tick();
    do_write(6, 2, 800);
    check_eq("t2_rate_wr", 32'(rate_of(6)), 800);
    pulse_evt(1, 2, 1, 3);
    check_eq("t2_rate_derated", 32'(rate_of(6)), 100);
    check_eq("t2_shape", 32'(ps_fifo_enable_shaping_out[6]), 1);
    check_eq("t2_rate7_untouched", 32'(rate_of(7)), 1);
    do_read(6, 5, rv, rd);
    check_eq("t2_status", 32'(rd), 27);

    // 3: decay steps
    wait_tick();
    check_eq("t3_rate_sev2", 32'(rate_of(6)), 200);
    wait_tick();
    check_eq("t3_rate_sev1", 32'(rate_of(6)), 400);
    wait_tick();
    check_eq("t3_rate_sev0", 32'(rate_of(6)), 800);
    check_eq("t3_shape_sev0", 32'(ps_fifo_enable_shaping_out[6]), 1);
    wait_tick();
    check_eq("t3_rate_clear", 32'(rate_of(6)), 800);
    check_eq("t3_shape_clear", 32'(ps_fifo_enable_shaping_out[6]), 0);
    do_read(6, 5, rv, rd);
    check_eq("t3_status_clear", 32'(rd), 0);

    // 4: escalate-only severity, then write beats event on FIFO 0
    wait_tick();
    pulse_evt(0, 0, 1, 2);
    pulse_evt(0, 0, 2, 1);
    do_read(0, 5, rv, rd);
    check_eq("t4_status_keep_sev", 32'(rd), 21);
    set_wr(0, 3, 77);
    set_evt(0, 0, 3, 5);
    @(negedge clk);
    idle_inputs();
    check_eq("t4_shape_wr_wins", 32'(ps_fifo_enable_shaping_out[0]), 0);
    check_eq("t4_quant", 32'(quant_of(0)), 77);
    do_read(0, 5, rv, rd);
    check_eq("t4_status_wr_wins", 32'(rd), 0);
    do_read(0, 3, rv, rd);
    check_eq("t4_rd_quant", 32'(rd), 77);
    do_write(3, 0, 9);
    check_eq("t4_prio3", 32'(prio_of(3)), 9);

    // 5: derating floor, zero rate, invalid writes and reads
    wait_tick();
    do_write(11, 2, 3);
    do_write(7, 2, 0);
    set_evt(1, 3, 0, 2);
    set_evt(2, 3, 3, 7);
    @(negedge clk);
    idle_inputs();
    check_eq("t5_rate_floor", 32'(rate_of(11)), 1);
    check_eq("t5_rate_zero", 32'(rate_of(7)), 0);
    check_eq("t5_shape7", 32'(ps_fifo_enable_shaping_out[7]), 1);
    do_write(12, 2, 999);
    check_eq("t5_bad_fifo_rate0", 32'(rate_of(0)), 1);
    do_read(12, 2, rv, rd);
    check_eq("t5_bad_fifo_valid", 32'(rv), 1);
    check_eq("t5_bad_fifo_data", 32'(rd), 0);
    do_write(11, 6, 55);
    check_eq("t5_bad_param_keep", 32'(ps_fifo_enable_shaping_out[11]), 1);
    do_read(11, 5, rv, rd);
    check_eq("t5_status11", 32'(rd), 63);
    do_read(0, 6, rv, rd);
    check_eq("t5_bad_param_rd", 32'(rd), 0);

    // 6: reset with FIFO 6 congested and a read pending
    pulse_evt(1, 2, 1, 4);
    check_eq("t6_rate_cong", 32'(rate_of(6)), 50);
    cfg_bus.cfg_rd_en    = 1'b1;
    cfg_bus.cfg_rd_fifo  = 4'(6);
    cfg_bus.cfg_rd_param = 3'(2);
    rst = 1'b1;
    @(negedge clk);
    cfg_bus.cfg_rd_en = 1'b0;
    check_eq("t6_rd_valid", 32'(cfg_bus.cfg_rd_valid), 0);
    check_eq("t6_rd_data", 32'(cfg_bus.cfg_rd_data), 0);
    check_eq("t6_rate6", 32'(rate_of(6)), 1);
    check_eq("t6_shape6", 32'(ps_fifo_enable_shaping_out[6]), 0);
    check_eq("t6_prio3", 32'(prio_of(3)), 1);
    check_eq("t6_quant0", 32'(quant_of(0)), 500);
    rst = 1'b0;
    do_read(6, 5, rv, rd);
    check_eq("t6_status6", 32'(rd), 0);
    do_read(6, 2, rv, rd);
    check_eq("t6_rd_rate6", 32'(rd), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
